// File: rtl/vga_pkg.sv
// Shared types and geometry for the 160x120 reduced-VGA plot sink.
package vga_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned FB_DEPTH = 19200;

  typedef logic [2:0]  colour_t;
  typedef logic [7:0]  xcoord_t;
  typedef logic [6:0]  ycoord_t;
  typedef logic [14:0] fbaddr_t;

  typedef enum logic {CLEAR, RUN} sink_state_t;

  // y*160 + x as two shifts and adds, kept within 15 bits
  function automatic fbaddr_t fb_addr(input xcoord_t x, input ycoord_t y);
    fbaddr_t yw;
    yw = fbaddr_t'(y);
    return (yw << 7) + (yw << 5) + fbaddr_t'(x);
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer: one write port, one synchronous read port
// returning the old word on a same-address read/write.
module fb_ram
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [14:0] waddr,
  input  logic [2:0]  wdata,
  input  logic [14:0] raddr,
  output logic [2:0]  rdata
);

  colour_t mem [FB_DEPTH];
  colour_t rd_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rd_q <= mem[raddr];
  end

  assign rdata = rd_q;

endmodule

// File: rtl/vga_plot_sink.sv
// Plot-interface sink: clears and writes a 160x120x3 framebuffer and scans
// it out continuously as a timed pixel stream with sync pulses.
module vga_plot_sink
  import vga_pkg::*;
#(
  parameter int unsigned H_FP   = 4,
  parameter int unsigned H_SYNC = 8,
  parameter int unsigned H_BP   = 4,
  parameter int unsigned V_FP   = 2,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        plot,
  input  logic [7:0]  plot_x,
  input  logic [6:0]  plot_y,
  input  logic [2:0]  plot_colour,
  output logic        plot_ready,
  input  logic        clear,
  output logic [7:0]  pix_x,
  output logic [6:0]  pix_y,
  output logic [2:0]  pix_colour,
  output logic        pix_valid,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        frame_start,
  output logic [14:0] plot_count,
  output logic [7:0]  drop_count
);

  localparam int unsigned H_TOTAL = SCREEN_W + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = SCREEN_H + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(SCREEN_W);
  localparam logic [9:0] HS_ON  = 10'(SCREEN_W + H_FP);
  localparam logic [9:0] HS_OFF = 10'(SCREEN_W + H_FP + H_SYNC);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_ACT  = 9'(SCREEN_H);
  localparam logic [8:0] VS_ON  = 9'(SCREEN_H + V_FP);
  localparam logic [8:0] VS_OFF = 9'(SCREEN_H + V_FP + V_SYNC);

  localparam fbaddr_t FB_LAST = fbaddr_t'(FB_DEPTH - 1);

  // ---------------------------------------------------------------- write side
  sink_state_t state_q, state_d;
  fbaddr_t     clr_addr_q, clr_addr_d;
  logic [14:0] plot_count_q, plot_count_d;
  logic [7:0]  drop_count_q, drop_count_d;

  logic        we;
  fbaddr_t     waddr;
  colour_t     wdata;
  logic        in_range;

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    plot_count_d = plot_count_q;
    drop_count_d = drop_count_q;
    we           = 1'b0;
    waddr        = clr_addr_q;
    wdata        = '0;
    in_range     = (plot_x < 8'(SCREEN_W)) && (plot_y < 7'(SCREEN_H));

    case (state_q)
      CLEAR: begin
        we = 1'b1;
        if (clear) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == FB_LAST) begin
          clr_addr_d = '0;
          state_d    = RUN;
        end else begin
          clr_addr_d = clr_addr_q + 15'd1;
        end
      end
      RUN: begin
        // clear wins over a plot presented in the same cycle
        if (clear) begin
          clr_addr_d = '0;
          state_d    = CLEAR;
        end else if (plot) begin
          if (in_range) begin
            we    = 1'b1;
            waddr = fb_addr(plot_x, plot_y);
            wdata = plot_colour;
            if (plot_count_q != '1) begin
              plot_count_d = plot_count_q + 15'd1;
            end
          end else if (drop_count_q != '1) begin
            drop_count_d = drop_count_q + 8'd1;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      clr_addr_q   <= '0;
      plot_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      plot_count_q <= plot_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign plot_ready = (state_q == RUN);
  assign plot_count = plot_count_q;
  assign drop_count = drop_count_q;

  // ---------------------------------------------------------------- scan side
  logic [9:0] h_q, h_d;
  logic [8:0] v_q, v_d;
  logic       active;
  fbaddr_t    raddr;
  colour_t    rdata;

  xcoord_t pix_x_q, pix_x_d;
  ycoord_t pix_y_q, pix_y_d;
  logic    pix_valid_q, pix_valid_d;
  logic    hsync_n_q, hsync_n_d;
  logic    vsync_n_q, vsync_n_d;
  logic    frame_start_q, frame_start_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 9'd1;
    end

    active = (h_q < H_ACT) && (v_q < V_ACT);
    raddr  = active ? fb_addr(xcoord_t'(h_q), ycoord_t'(v_q)) : '0;

    // registered alongside the RAM read so they line up with rdata
    pix_x_d       = xcoord_t'(h_q);
    pix_y_d       = ycoord_t'(v_q);
    pix_valid_d   = active;
    hsync_n_d     = !((h_q >= HS_ON) && (h_q < HS_OFF));
    vsync_n_d     = !((v_q >= VS_ON) && (v_q < VS_OFF));
    frame_start_d = (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_valid_q   <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_valid_q   <= pix_valid_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  fb_ram u_fb_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_valid   = pix_valid_q;
  assign pix_colour  = pix_valid_q ? rdata : '0;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_plot_sink.md
Name: vga_plot_sink

Overview:
- Receiving end of the 160x120 reduced-VGA plot interface (x, y, colour, plot strobe) driven by the screen-fill and drawing engines.
- Writes accepted plots into an on-chip 19200x3 framebuffer.
- Continuously scans the framebuffer out as a timed pixel stream with sync pulses for the display path.
- On reset or on request it clears the framebuffer to colour 0 before accepting plots.

Parameters:
- H_FP, 4: horizontal front porch, pixels
- H_SYNC, 8: horizontal sync width, pixels
- H_BP, 4: horizontal back porch, pixels
- V_FP, 2: vertical front porch, lines
- V_SYNC, 2: vertical sync width, lines
- V_BP, 2: vertical back porch, lines

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- plot  in  1  plot strobe; one write per cycle while high
- plot_x  in  8  column, valid 0..159
- plot_y  in  7  row, valid 0..119
- plot_colour  in  3  pixel colour
- plot_ready  out  1  high in RUN; plots are ignored when low
- clear  in  1  1-cycle pulse; refills framebuffer with colour 0
- pix_x  out  8  scanout column
- pix_y  out  7  scanout row
- pix_colour  out  3  scanout colour; 0 outside the active area
- pix_valid  out  1  scanout is in the active area
- hsync_n  out  1  active-low horizontal sync
- vsync_n  out  1  active-low vertical sync
- frame_start  out  1  1-cycle pulse with pixel (0,0)
- plot_count  out  15  accepted in-range plots, saturates at 32767
- drop_count  out  8  out-of-range plots while ready, saturates at 255

Behaviour:
- Reset values:
  - FSM=CLEAR, clear address=0, plot_ready=0
  - h/v counters=0, pix_*=0, pix_valid=0, hsync_n=1, vsync_n=1, frame_start=0
  - plot_count=0, drop_count=0
- FSM CLEAR:
  - Writes colour 0 to address clr_addr each cycle, clr_addr 0..19199, then -> RUN (19200 cycles).
  - plot_ready=0; any plot is ignored and not counted.
  - Scanout keeps running during CLEAR.
- FSM RUN:
  - plot_ready=1.
  - In-range plot (x<160, y<120): write colour at addr = y*160+x, computed as (y<<7)+(y<<5)+x in 15 bits; plot_count+1.
  - Out-of-range plot: no write; drop_count+1.
- clear pulse:
  - In RUN -> CLEAR with clr_addr=0; the plot in the same cycle is ignored.
  - In CLEAR -> clr_addr restarts at 0.
- Timing counters:
  - h counter runs 0..H_TOTAL-1, H_TOTAL = 160+H_FP+H_SYNC+H_BP (176 by default).
  - v counter increments on h wrap and runs 0..V_TOTAL-1, V_TOTAL = 120+V_FP+V_SYNC+V_BP (126 by default).
  - Frame length is 22176 cycles.
- Sync pulses:
  - hsync active for h in [160+H_FP, 160+H_FP+H_SYNC).
  - vsync active for v in [120+V_FP, 120+V_FP+V_SYNC).
- Scanout pipeline:
  - Framebuffer read port is synchronous, 1-cycle latency.
  - All scanout outputs are registered one cycle after the counter state that produced them, so they stay aligned with read data.
  - frame_start is high exactly when pix_valid=1 and pix_x=0, pix_y=0.
- Read/write collision on the same address in the same cycle: read returns old data; new data is visible from the next read.
- Scanout is never stalled by plots.
- Simultaneous clear and reset: reset dominates.
- Mid-operation reset: all state returns to reset values asynchronously; framebuffer contents are undefined until CLEAR completes.
- Counters hold at saturation and are reset only by rst_n; clear does not reset them.

Decomposition:
- Package vga_pkg holds:
  - constants SCREEN_W=160, SCREEN_H=120, FB_DEPTH=19200
  - typedefs colour_t [2:0], xcoord_t [7:0], ycoord_t [6:0], fbaddr_t [14:0]
  - enum sink_state_t {CLEAR, RUN}
- Sub-module fb_ram: simple dual-port RAM, FB_DEPTH x 3, one write port, one synchronous read port, old-data read-during-write.
- Address arithmetic and both FSMs stay in vga_plot_sink.

Test Plan:
- Reset release -> plot_ready=0 for exactly 19200 cycles, then 1; first full frame after that shows pix_colour=0 at all 19200 active pixels.
- After CLEAR, plot (0,0,c=5) and (159,119,c=2), then wait one frame:
  - frame_start coincides with pix_colour=5.
  - pixel (159,119) reads 2.
  - plot_count=2.
- Fill sweep of 19200 plots, colour = x[2:0]:
  - Every scanned pixel equals its x mod 8.
  - plot_count=19200, drop_count=0.
- Plots at (160,0), (0,120), (255,127) -> no framebuffer change, drop_count=3, plot_count unchanged.
- Plot (10,10,c=7) in the same cycle scanout reads (10,10) -> that frame shows the old value; next frame shows 7.
- Mid-RUN clear, plus rst_n low mid-CLEAR:
  - clear pulse -> plot_ready=0 for 19200 cycles and framebuffer is all 0.
  - rst_n low mid-CLEAR -> immediate reset values; CLEAR restarts at address 0.
